// File: rtl/rv32_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 width codes,
// sequencer states and the op legality check.
package rv32_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FIN  = 2'd2,
        S_ERR  = 2'd3
    } lsu_state_t;

    // An op is rejected before any bus access when its funct3 is not a legal
    // RV32I load/store width or its address is not naturally aligned.
    function automatic logic op_is_bad(input logic       is_store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                     (is_store && funct3[2]);
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it
// according to the RV32I load width.
module load_align
    import rv32_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'd0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer: one memory op per start pulse over a
// valid/ack bus, with a single register-file write for loads.
module load_store_unit
    import rv32_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] sdata,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_wraddr,
    output logic [31:0] rf_wrdata,
    output logic        busy,
    output logic        done,
    output logic        err_misalign,
    output logic        err_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             is_store_q;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic [4:0]       rd_q;

    logic [31:0]      lane_wdata;
    logic [3:0]       lane_be;
    logic [31:0]      load_result;

    // Bus lanes are derived from the incoming op so they are registered
    // alongside the REQ transition and stay stable for the whole request.
    always_comb begin
        lane_wdata = sdata;
        lane_be    = 4'b1111;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    lane_wdata = {4{sdata[7:0]}};
                    lane_be    = 4'b0001 << addr[1:0];
                end
                2'b01: begin
                    lane_wdata = {2{sdata[15:0]}};
                    lane_be    = addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    lane_wdata = sdata;
                    lane_be    = 4'b1111;
                end
            endcase
        end
    end

    load_align u_load_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_lo_q),
        .funct3  (funct3_q),
        .result  (load_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            rd_q         <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            rf_we        <= 1'b0;
            rf_wraddr    <= '0;
            rf_wrdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            done         <= 1'b0;
            rf_we        <= 1'b0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_store_q <= is_store;
                        funct3_q   <= funct3;
                        addr_lo_q  <= addr[1:0];
                        rd_q       <= rd;
                        mem_we     <= is_store;
                        mem_addr   <= {addr[31:2], 2'b00};
                        mem_wdata  <= lane_wdata;
                        mem_be     <= lane_be;
                        busy       <= 1'b1;
                        if (op_is_bad(is_store, funct3, addr[1:0])) begin
                            state        <= S_ERR;
                            err_misalign <= 1'b1;
                        end else begin
                            state   <= S_REQ;
                            mem_req <= 1'b1;
                            cnt     <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        state     <= S_FIN;
                        mem_req   <= 1'b0;
                        done      <= 1'b1;
                        rf_we     <= !is_store_q && (rd_q != 5'd0);
                        rf_wraddr <= rd_q;
                        rf_wrdata <= load_result;
                    end else if (cnt == CNT_LAST) begin
                        state       <= S_ERR;
                        mem_req     <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FIN, S_ERR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single ops plus
// hand sequences for timeout, reset mid-op and start-while-busy.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_wraddr;
    logic [31:0] rf_wrdata;
    logic        busy;
    logic        done;
    logic        err_misalign;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYC(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .is_store     (is_store),
        .funct3       (funct3),
        .addr         (addr),
        .sdata        (sdata),
        .rd           (rd),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .rf_we        (rf_we),
        .rf_wraddr    (rf_wraddr),
        .rf_wrdata    (rf_wrdata),
        .busy         (busy),
        .done         (done),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          dly;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rfwe;
        logic [31:0] rfdata;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        is_store = v.st;
        funct3   = v.f3;
        addr     = v.addr;
        sdata    = v.sdata;
        rd       = v.rd;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        if (v.mis) begin
            chk("err_misalign", {31'd0, err_misalign}, 32'd1);
            chk("mis_no_req", {31'd0, mem_req}, 32'd0);
            tick();
            chk("mis_pulse_end", {31'd0, err_misalign}, 32'd0);
            chk("mis_no_req2", {31'd0, mem_req}, 32'd0);
            chk("mis_no_rf_we", {31'd0, rf_we}, 32'd0);
            chk("mis_idle", {31'd0, busy}, 32'd0);
        end else begin
            chk("mem_req", {31'd0, mem_req}, 32'd1);
            chk("mem_we", {31'd0, mem_we}, {31'd0, v.st});
            chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
            chk("mem_be", {28'd0, mem_be}, {28'd0, v.be});
            if (v.st) chk("mem_wdata", mem_wdata, v.wdata);
            for (int i = 0; i < v.dly; i++) begin
                tick();
                chk("req_held", {31'd0, mem_req}, 32'd1);
                chk("no_early_done", {31'd0, done}, 32'd0);
            end
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
            tick();
            mem_ack   = 1'b0;
            chk("done", {31'd0, done}, 32'd1);
            chk("req_dropped", {31'd0, mem_req}, 32'd0);
            chk("rf_we", {31'd0, rf_we}, {31'd0, v.rfwe});
            if (v.rfwe) begin
                chk("rf_wraddr", {27'd0, rf_wraddr}, {27'd0, v.rd});
                chk("rf_wrdata", rf_wrdata, v.rfdata);
            end
            tick();
            chk("done_pulse_end", {31'd0, done}, 32'd0);
            chk("rf_we_pulse_end", {31'd0, rf_we}, 32'd0);
            chk("back_idle", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int req_cycles;

        //              st    f3      addr          sdata         rd     rdata         dly mis be       wdata         rfwe  rfdata
        vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        5'd5,  32'hDEAD_BEEF, 0, 1'b0, 4'b1111, 32'h0,        1'b1, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        5'd6,  32'h80FF_7F01, 0, 1'b0, 4'b1111, 32'h0,        1'b1, 32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        5'd7,  32'h80FF_7F01, 1, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h0000_0080};
        vecs[3]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        5'd8,  32'h80FF_7F01, 0, 1'b0, 4'b1111, 32'h0,        1'b1, 32'hFFFF_80FF};
        vecs[4]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,        5'd9,  32'h80FF_7F01, 2, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h0000_7F01};
        vecs[5]  = '{1'b0, 3'b000, 32'h0000_0101, 32'h0,        5'd10, 32'h80FF_7F01, 0, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h0000_007F};
        vecs[6]  = '{1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 5'd3, 32'h0,         0, 1'b0, 4'b0010, 32'hABAB_ABAB, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 3'b001, 32'h0000_0302, 32'h1234_CAFE, 5'd3, 32'h0,         1, 1'b0, 4'b1100, 32'hCAFE_CAFE, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 3'b010, 32'h0000_0404, 32'h1122_3344, 5'd3, 32'h0,         3, 1'b0, 4'b1111, 32'h1122_3344, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 3'b010, 32'h0000_0102, 32'h0,        5'd5,  32'h0,         0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[10] = '{1'b0, 3'b001, 32'h0000_0101, 32'h0,        5'd5,  32'h0,         0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[11] = '{1'b1, 3'b100, 32'h0000_0200, 32'h0,        5'd5,  32'h0,         0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[12] = '{1'b0, 3'b010, 32'h0000_0500, 32'h0,        5'd0,  32'h1234_5678, 0, 1'b0, 4'b1111, 32'h0,        1'b0, 32'h0};
        vecs[13] = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,        5'd5,  32'h0,         0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0};

        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0;
        sdata = '0; rd = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_errs", {30'd0, err_misalign, err_timeout}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // Timeout: ack withheld for the whole request window, then a late ack.
        is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0600; rd = 5'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!mem_req) break;
            req_cycles++;
            tick();
        end
        chk("timeout_req_cycles", req_cycles, 32'd16);
        chk("err_timeout", {31'd0, err_timeout}, 32'd1);
        chk("timeout_no_done", {31'd0, done}, 32'd0);
        chk("timeout_no_rf_we", {31'd0, rf_we}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        chk("late_ack_no_rf_we", {31'd0, rf_we}, 32'd0);
        chk("late_ack_no_done", {31'd0, done}, 32'd0);
        chk("late_ack_no_req", {31'd0, mem_req}, 32'd0);
        chk("timeout_pulse_end", {31'd0, err_timeout}, 32'd0);
        chk("timeout_idle", {31'd0, busy}, 32'd0);
        mem_ack = 1'b0;
        tick();
        run_vec(vecs[0]);

        // Reset asserted during REQ drops the request asynchronously.
        is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0700; rd = 5'd12;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("pre_reset_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req_drop", {31'd0, mem_req}, 32'd0);
        chk("async_busy_drop", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
        tick();
        chk("post_reset_no_rf_we", {31'd0, rf_we}, 32'd0);
        chk("post_reset_no_done", {31'd0, done}, 32'd0);
        chk("post_reset_no_req", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b0;
        tick();

        // start pulses while busy are ignored.
        is_store = 1'b1; funct3 = 3'b010; addr = 32'h0000_0800; sdata = 32'h0000_0055; rd = 5'd1;
        start = 1'b1;
        tick();
        is_store = 1'b0; addr = 32'h0000_0900;
        tick();
        start = 1'b0;
        chk("busy_ign_addr", mem_addr, 32'h0000_0800);
        chk("busy_ign_we", {31'd0, mem_we}, 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("busy_ign_done", {31'd0, done}, 32'd1);
        start = 1'b1; addr = 32'h0000_0A00;
        tick();
        start = 1'b0;
        chk("fin_start_ignored_busy", {31'd0, busy}, 32'd0);
        chk("fin_start_ignored_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("still_idle_busy", {31'd0, busy}, 32'd0);
        chk("still_idle_req", {31'd0, mem_req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
